// File: rtl/match_share_arb.sv
// Round-robin arbiter that time-shares one sequence matcher among NREQ requesters,
// forwarding the owner's element stream and routing the resulting hit burst back.
module match_share_arb #(
  parameter int NREQ   = 2,
  parameter int MAXLEN = 10,
  parameter int TMO    = 4
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [3:0]          num,
  input  logic [NREQ-1:0]     req,
  input  logic [4*NREQ-1:0]   seq_in,
  output logic [NREQ-1:0]     gnt,
  output logic                m_valid,
  output logic [3:0]          m_num,
  output logic [3:0]          m_seq,
  input  logic                m_hit,
  output logic [NREQ-1:0]     hit_out,
  output logic                busy,
  output logic                err_miss,
  output logic                err_spur,
  output logic [1:0]          dbg_state
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  localparam logic [3:0] MAXLEN_C = 4'(MAXLEN);
  localparam logic [3:0] TMO_C    = 4'(TMO);

  // Handshake: while granted, req[owner] is the element valid and m_valid mirrors it
  // combinationally; there is no back-pressure, every valid element is consumed.

  logic [1:0]    state;
  logic [IW-1:0] owner;
  logic [IW-1:0] rr_ptr;
  logic [3:0]    num_q;
  logic [3:0]    len;
  logic [3:0]    exp_cnt;
  logic [3:0]    wait_cnt;

  logic [IW-1:0] pick;
  logic [IW-1:0] idx;
  logic          pick_found;
  logic          owner_req;
  logic [3:0]    owner_seq;
  logic          drain_live;

  // First set request strictly after the last owner, wrapping modulo NREQ.
  always_comb begin
    pick       = rr_ptr;
    pick_found = 1'b0;
    idx        = '0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = IW'((int'(rr_ptr) + k) % NREQ);
      if (!pick_found && req[idx]) begin
        pick       = idx;
        pick_found = 1'b1;
      end
    end
  end

  assign owner_req  = req[owner];
  assign owner_seq  = seq_in[4*int'(owner) +: 4];
  assign drain_live = (state == S_DRAIN) && (exp_cnt != 4'd0);

  assign m_valid   = (state == S_RUN) && owner_req;
  assign m_seq     = (state == S_RUN) ? owner_seq : 4'd0;
  assign m_num     = (state == S_RUN) ? num_q : 4'd0;
  assign hit_out   = (drain_live && m_hit) ? (NREQ'(1) << owner) : '0;
  assign busy      = (state != S_IDLE);
  assign dbg_state = state;

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= S_IDLE;
      owner    <= '0;
      rr_ptr   <= IW'(NREQ - 1);
      num_q    <= 4'd0;
      len      <= 4'd0;
      exp_cnt  <= 4'd0;
      wait_cnt <= 4'd0;
      gnt      <= '0;
      err_miss <= 1'b0;
      err_spur <= 1'b0;
    end else begin
      err_miss <= 1'b0;
      // A hit is only legitimate while a drain still expects one.
      err_spur <= m_hit && !drain_live;
      case (state)
        S_IDLE: begin
          if (pick_found) begin
            owner   <= pick;
            gnt     <= NREQ'(1) << pick;
            num_q   <= num;
            len     <= 4'd0;
            exp_cnt <= 4'd0;
            state   <= S_RUN;
          end
        end
        S_RUN: begin
          if (!owner_req || (len + 4'd1 == MAXLEN_C)) begin
            state    <= S_DRAIN;
            gnt      <= '0;
            rr_ptr   <= owner;
            wait_cnt <= 4'd0;
          end
          if (owner_req) begin
            len <= len + 4'd1;
            if (owner_seq == num_q) exp_cnt <= exp_cnt + 4'd1;
          end
        end
        S_DRAIN: begin
          if (exp_cnt == 4'd0) begin
            state <= S_IDLE;
          end else if (m_hit) begin
            exp_cnt  <= exp_cnt - 4'd1;
            wait_cnt <= 4'd0;
            if (exp_cnt == 4'd1) state <= S_IDLE;
          end else begin
            wait_cnt <= wait_cnt + 4'd1;
            if (wait_cnt + 4'd1 == TMO_C) begin
              err_miss <= 1'b1;
              exp_cnt  <= 4'd0;
              state    <= S_IDLE;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_match_share_arb.sv
// Directed bench for match_share_arb: inputs change 1 ns after the rising edge,
// outputs are sampled 2 ns after it, well away from the next edge.
module tb_match_share_arb;
  localparam int NREQ = 2;

  logic              clock = 1'b0;
  logic              reset;
  logic [3:0]        num;
  logic [NREQ-1:0]   req;
  logic [4*NREQ-1:0] seq_in;
  logic [NREQ-1:0]   gnt;
  logic              m_valid;
  logic [3:0]        m_num;
  logic [3:0]        m_seq;
  logic              m_hit;
  logic [NREQ-1:0]   hit_out;
  logic              busy;
  logic              err_miss;
  logic              err_spur;
  logic [1:0]        dbg_state;

  int tests_run    = 0;
  int tests_failed = 0;
  logic [NREQ-1:0] exp_q[$];
  logic [NREQ-1:0] want_owner;

  match_share_arb #(.NREQ(NREQ), .MAXLEN(10), .TMO(4)) dut (
    .clock(clock), .reset(reset), .num(num), .req(req), .seq_in(seq_in),
    .gnt(gnt), .m_valid(m_valid), .m_num(m_num), .m_seq(m_seq), .m_hit(m_hit),
    .hit_out(hit_out), .busy(busy), .err_miss(err_miss), .err_spur(err_spur),
    .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    tests_run++;
    if (got !== want) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  // Grant from IDLE, stream n_elem elements (< MAXLEN), then owner drops req.
  task automatic grant_burst(input logic [NREQ-1:0] req_all, input logic [NREQ-1:0] owner_oh,
                             input int n_elem, input string tag);
    cyc(); req = req_all; settle();
    check({tag, "_idle_gnt"}, 32'(gnt), 0);
    check({tag, "_idle_busy"}, 32'(busy), 0);
    for (int i = 0; i < n_elem; i++) begin
      cyc(); settle();
      check({tag, "_run_gnt"}, 32'(gnt), 32'(owner_oh));
      check({tag, "_run_valid"}, 32'(m_valid), 1);
    end
    cyc(); req = req_all & ~owner_oh; settle();
    check({tag, "_end_gnt"}, 32'(gnt), 32'(owner_oh));
    check({tag, "_end_valid"}, 32'(m_valid), 0);
  endtask

  // Matcher answers with n_hits back-to-back hits starting in the first DRAIN cycle.
  task automatic drain(input logic [NREQ-1:0] owner_oh, input int n_hits, input string tag);
    for (int i = 0; i < n_hits; i++) begin
      cyc(); req = '0; m_hit = 1'b1; settle();
      check({tag, "_hit_out"}, 32'(hit_out), 32'(owner_oh));
      check({tag, "_drain_gnt"}, 32'(gnt), 0);
      check({tag, "_drain_valid"}, 32'(m_valid), 0);
      check({tag, "_drain_busy"}, 32'(busy), 1);
    end
    cyc(); m_hit = 1'b0; settle();
    check({tag, "_post_busy"}, 32'(busy), 0);
    check({tag, "_post_spur"}, 32'(err_spur), 0);
    check({tag, "_post_miss"}, 32'(err_miss), 0);
  endtask

  initial begin
    reset = 1'b1; req = '0; m_hit = 1'b0; num = 4'd0; seq_in = '0;
    cyc(); cyc(); settle();
    check("rst_gnt", 32'(gnt), 0);
    check("rst_valid", 32'(m_valid), 0);
    check("rst_num", 32'(m_num), 0);
    check("rst_seq", 32'(m_seq), 0);
    check("rst_hit_out", 32'(hit_out), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_errs", 32'({err_miss, err_spur}), 0);
    check("rst_state", 32'(dbg_state), 0);
    reset = 1'b0;

    // 10 matching elements from requester 0, 10 hits back
    num = 4'd5; seq_in = {4'd0, 4'd5};
    cyc(); req = 2'b01; settle();
    check("t1_idle_gnt", 32'(gnt), 0);
    for (int i = 0; i < 10; i++) begin
      cyc(); settle();
      check("t1_gnt", 32'(gnt), 32'h1);
      check("t1_valid", 32'(m_valid), 1);
      check("t1_seq", 32'(m_seq), 5);
      check("t1_num", 32'(m_num), 5);
    end
    drain(2'b01, 10, "t1");

    // requester 1, no matches: one-cycle drain, injected hit is spurious
    seq_in = {4'd10, 4'd5};
    cyc(); req = 2'b10; settle();
    check("t2_idle_gnt", 32'(gnt), 0);
    for (int i = 0; i < 10; i++) begin
      cyc(); settle();
      check("t2_gnt", 32'(gnt), 32'h2);
      check("t2_seq", 32'(m_seq), 10);
    end
    cyc(); req = '0; m_hit = 1'b1; settle();
    check("t2_drain_busy", 32'(busy), 1);
    check("t2_hit_out", 32'(hit_out), 0);
    cyc(); m_hit = 1'b0; settle();
    check("t2_idle_busy", 32'(busy), 0);
    check("t2_spur", 32'(err_spur), 1);
    cyc(); settle();
    check("t2_spur_clear", 32'(err_spur), 0);

    // simultaneous requests, strict round-robin
    seq_in = {4'd5, 4'd5};
    exp_q.push_back(2'b01);
    exp_q.push_back(2'b10);
    exp_q.push_back(2'b01);
    while (exp_q.size() > 0) begin
      want_owner = exp_q.pop_front();
      grant_burst(2'b11, want_owner, 1, "t3");
      drain(want_owner, 1, "t3");
    end

    // 14 matching elements held by requester 0: truncated at 10
    cyc(); req = 2'b01; settle();
    check("t4_idle_gnt", 32'(gnt), 0);
    for (int i = 0; i < 10; i++) begin
      cyc(); settle();
      check("t4_gnt", 32'(gnt), 32'h1);
      check("t4_valid", 32'(m_valid), 1);
    end
    for (int i = 0; i < 10; i++) begin
      cyc(); req = (i < 4) ? 2'b01 : 2'b00; m_hit = 1'b1; settle();
      check("t4_hit_out", 32'(hit_out), 32'h1);
      check("t4_drain_gnt", 32'(gnt), 0);
      check("t4_drain_valid", 32'(m_valid), 0);
      check("t4_drain_busy", 32'(busy), 1);
    end
    cyc(); m_hit = 1'b0; req = '0; settle();
    check("t4_post_busy", 32'(busy), 0);
    check("t4_post_errs", 32'({err_miss, err_spur}), 0);

    // 3 matches, 1 hit then silence: err_miss after 4 hit-less cycles
    grant_burst(2'b10, 2'b10, 3, "t5");
    cyc(); req = '0; m_hit = 1'b1; settle();
    check("t5_hit_out", 32'(hit_out), 32'h2);
    for (int i = 0; i < 4; i++) begin
      cyc(); m_hit = 1'b0; settle();
      check("t5_wait_busy", 32'(busy), 1);
      check("t5_wait_miss", 32'(err_miss), 0);
    end
    cyc(); settle();
    check("t5_busy", 32'(busy), 0);
    check("t5_miss", 32'(err_miss), 1);
    check("t5_state", 32'(dbg_state), 0);
    cyc(); settle();
    check("t5_miss_clear", 32'(err_miss), 0);

    // reset while draining with 3 hits outstanding
    grant_burst(2'b01, 2'b01, 3, "t6");
    cyc(); req = '0; reset = 1'b1; settle();
    check("t6_drain_busy", 32'(busy), 1);
    cyc(); reset = 1'b0; m_hit = 1'b1; settle();
    check("t6_busy", 32'(busy), 0);
    check("t6_gnt", 32'(gnt), 0);
    check("t6_valid", 32'(m_valid), 0);
    check("t6_hit_out", 32'(hit_out), 0);
    check("t6_num_seq", 32'({m_num, m_seq}), 0);
    check("t6_errs", 32'({err_miss, err_spur}), 0);
    cyc(); m_hit = 1'b0; settle();
    check("t6_spur", 32'(err_spur), 1);
    check("t6_miss", 32'(err_miss), 0);
    // round-robin pointer restored: requester 0 wins a tie again
    grant_burst(2'b11, 2'b01, 1, "t6rr");
    drain(2'b01, 1, "t6rr");

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
